// File: rtl/demux_lane_sequencer_pkg.sv
// Shared types and defaults for the demux lane sequencer.
package demux_seq_pkg;

    // Default lane count and matching select width
    localparam int N_LANES_DEF = 4;
    localparam int SEL_W       = $clog2(N_LANES_DEF);

    // IDLE: nothing on dout; HOLD: dout/sel valid, waiting for the selected lane
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/demux_lane_sequencer_pick.sv
// Combinational lane picker for the demux lane sequencer.
// Optional feature macro: DEMUX_SKIP_BUSY_EN
//   defined     : scan from ptr upward (mod N_LANES) for the first ready lane,
//                 falling back to ptr when no lane is ready
//   not defined : strict round-robin, sel = ptr
module rr_lane_pick
    import demux_seq_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int SEL_W   = $clog2(N_LANES)
) (
    input  logic [SEL_W-1:0]   ptr,
    input  logic [N_LANES-1:0] lane_ready,
    output logic [SEL_W-1:0]   sel
);

`ifdef DEMUX_SKIP_BUSY_EN
    // Scan downward so the ready lane closest to ptr is the last assignment and wins
    always_comb begin
        sel = ptr;
        for (int k = N_LANES - 1; k >= 0; k--) begin
            if (lane_ready[ptr + SEL_W'(k)]) begin
                sel = ptr + SEL_W'(k);
            end
        end
    end
`else
    // Strict round-robin ignores lane readiness when choosing the lane
    logic unused_lane_ready;
    assign unused_lane_ready = ^lane_ready;
    assign sel = ptr;
`endif

endmodule

// File: rtl/demux_lane_sequencer.sv
// Upstream driver for a 1:N demux: holds each item on dout, drives sel,
// advances lanes round-robin on acceptance and counts deliveries per lane.
// Optional feature macro: DEMUX_SKIP_BUSY_EN (skip lanes not ready at load time,
// implemented in rr_lane_pick).
module demux_lane_sequencer
    import demux_seq_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int N_LANES = N_LANES_DEF,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sync_clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [N_LANES-1:0]         lane_ready,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic [$clog2(N_LANES)-1:0] sel,
    output logic [N_LANES*CNT_W-1:0]   lane_cnt
);

    localparam int SEL_BITS = $clog2(N_LANES);

    state_t              state;
    state_t              state_nx;
    logic [SEL_BITS-1:0] ptr;
    logic [SEL_BITS-1:0] sel_inc;
    logic [SEL_BITS-1:0] pick_base;
    logic [SEL_BITS-1:0] pick_sel;
    logic [CNT_W-1:0]    cnt [N_LANES];
    logic                accept;
    logic                load;

    assign dout_valid = (state == HOLD);
    assign accept     = dout_valid & lane_ready[sel];
    // sync_clr blocks new items so nothing is loaded in the clearing cycle
    assign in_ready   = ~sync_clr & (~dout_valid | accept);
    assign load       = in_valid & in_ready;

    // On a back-to-back transfer the pointer update has not landed yet, so
    // the next lane is computed from the lane being accepted right now
    assign sel_inc   = sel + SEL_BITS'(1);
    assign pick_base = accept ? sel_inc : ptr;

    rr_lane_pick #(
        .N_LANES    (N_LANES),
        .SEL_W      (SEL_BITS)
    ) u_pick (
        .ptr        (pick_base),
        .lane_ready (lane_ready),
        .sel        (pick_sel)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: clear wins, otherwise IDLE/HOLD follow load and accept
    always_comb begin
        state_nx = state;
        if (sync_clr) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (load) state_nx = HOLD;
                HOLD:    if (accept) state_nx = load ? HOLD : IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Held item, lane select and round-robin pointer; sel only moves on load or clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            sel  <= '0;
            ptr  <= '0;
        end else if (sync_clr) begin
            sel  <= '0;
            ptr  <= '0;
        end else begin
            if (accept) begin
                ptr <= sel_inc;
            end
            if (load) begin
                dout <= in_data;
                sel  <= pick_sel;
            end
        end
    end

    // Per-lane delivery counters, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LANES; i++) begin
                cnt[i] <= '0;
            end
        end else if (sync_clr) begin
            for (int i = 0; i < N_LANES; i++) begin
                cnt[i] <= '0;
            end
        end else if (accept) begin
            cnt[sel] <= cnt[sel] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_pack
        assign lane_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end

endmodule
